display7seg_decoder: RTL and testbench

Multi-cycle decoder that turns four active-low 7-segment digit patterns (units, tens, hundreds, thousands) back into a 14-bit binary value in the range 0..9999. It is the inverse of the team's binary-to-decimal 7-segment display driver. Typical uses are loop-back self-test of the display path and ingesting digit patterns captured from a front panel. Input and output use valid/ready handshakes, and per-digit pattern errors are reported with the result.

---
 rtl/display7seg_decoder_if.sv | 24 ++
 rtl/display7seg_decoder.sv | 115 +++++++++++
 tb/tb_display7seg_decoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/display7seg_decoder_if.sv
// Handshake bundle for the 7-segment-to-binary decoder: segment input word,
// decoded result and the valid/ready pairs on both sides.
interface display7seg_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  seg_unidade;
    logic [6:0]  seg_dezena;
    logic [6:0]  seg_centena;
    logic [6:0]  seg_milhar;
    logic [13:0] valor;
    logic [3:0]  erro_mask;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_valid, seg_unidade, seg_dezena, seg_centena, seg_milhar, out_ready,
        input  in_ready, valor, erro_mask, out_valid
    );

    modport slave (
        input  in_valid, seg_unidade, seg_dezena, seg_centena, seg_milhar, out_ready,
        output in_ready, valor, erro_mask, out_valid
    );
endinterface

// File: rtl/display7seg_decoder.sv
// Decodes four active-low 7-segment digit patterns back into a binary value
// 0..9999, one digit per cycle (thousands first), flagging invalid patterns.
//
//   state | meaning
//   IDLE  | ready for a word; in_ready=1
//   CONV  | accumulating one digit per cycle, index 0..3 = milhar..unidade
//   DONE  | result presented; out_valid=1 until out_ready
module display7seg_decoder #(
    parameter bit BLANK_IS_ZERO = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    display7seg_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0][6:0]  seg_q;
    logic [13:0]      acc;
    logic [3:0]       mask_acc;
    logic [1:0]       idx;
    logic [13:0]      valor_q;
    logic [3:0]       erro_mask_q;

    logic [6:0]       cur_seg;
    logic [3:0]       digit;
    logic             dig_err;
    logic [13:0]      acc_nxt;
    logic [3:0]       mask_nxt;
    logic             accept;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.valor     = valor_q;
    assign bus.erro_mask = erro_mask_q;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign cur_seg = seg_q[idx];

    always_comb begin
        digit   = 4'd0;
        dig_err = 1'b0;
        case (cur_seg)
            7'b1000000: digit = 4'd0;
            7'b1111001: digit = 4'd1;
            7'b0100100: digit = 4'd2;
            7'b0110000: digit = 4'd3;
            7'b0011001: digit = 4'd4;
            7'b0010010: digit = 4'd5;
            7'b0000010: digit = 4'd6;
            7'b1111000: digit = 4'd7;
            7'b0000000: digit = 4'd8;
            7'b0010000: digit = 4'd9;
            7'b1111111: dig_err = !BLANK_IS_ZERO;
            default:    dig_err = 1'b1;
        endcase
    end

    // acc*10 as shift-add; result never exceeds 9999 so 14 bits suffice.
    always_comb begin
        acc_nxt  = (acc << 3) + (acc << 1) + {10'd0, digit};
        mask_nxt = mask_acc;
        if (dig_err) begin
            mask_nxt[2'd3 - idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = CONV;
            CONV: if (idx == 2'd3)  state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q       <= '0;
            acc         <= '0;
            mask_acc    <= '0;
            idx         <= '0;
            valor_q     <= '0;
            erro_mask_q <= '0;
        end else if (accept) begin
            seg_q    <= {bus.seg_unidade, bus.seg_dezena, bus.seg_centena, bus.seg_milhar};
            acc      <= '0;
            mask_acc <= '0;
            idx      <= '0;
        end else if (state == CONV) begin
            acc      <= acc_nxt;
            mask_acc <= mask_nxt;
            idx      <= idx + 2'd1;
            if (idx == 2'd3) begin
                valor_q     <= acc_nxt;
                erro_mask_q <= mask_nxt;
            end
        end
    end

endmodule

// File: tb/tb_display7seg_decoder.sv
// Directed bench for display7seg_decoder: two instances (blank-as-zero on and
// off) driven with identical stimulus, results compared to hand-worked values.
module tb_display7seg_decoder;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    localparam logic [6:0] SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    display7seg_decoder_if bus0 ();
    display7seg_decoder_if bus1 ();

    display7seg_decoder #(.BLANK_IS_ZERO(1'b1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    display7seg_decoder #(.BLANK_IS_ZERO(1'b0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] m, input logic [6:0] c,
                         input logic [6:0] d, input logic [6:0] u);
        bus0.in_valid = v; bus0.seg_milhar = m; bus0.seg_centena = c;
        bus0.seg_dezena = d; bus0.seg_unidade = u;
        bus1.in_valid = v; bus1.seg_milhar = m; bus1.seg_centena = c;
        bus1.seg_dezena = d; bus1.seg_unidade = u;
    endtask

    task automatic set_out_ready(input logic r);
        bus0.out_ready = r;
        bus1.out_ready = r;
    endtask

    // Accept one word and wait for out_valid; checks latency and in_ready.
    task automatic send(input string tag, input logic [6:0] m, input logic [6:0] c,
                        input logic [6:0] d, input logic [6:0] u);
        int lat;
        @(negedge clk);
        drive(1'b1, m, c, d, u);
        check({tag, " in_ready_before"}, int'(bus0.in_ready), 1);
        @(posedge clk);
        #1;
        drive(1'b0, 7'h55, 7'h2a, 7'h11, 7'h00);
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin
            check({tag, " in_ready_conv"}, int'(bus0.in_ready), 0);
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " in_ready_done"}, int'(bus0.in_ready), 0);
    endtask

    task automatic consume(input string tag);
        set_out_ready(1'b1);
        @(posedge clk);
        #1;
        set_out_ready(1'b0);
        check({tag, " out_valid_after"}, int'(bus0.out_valid), 0);
        check({tag, " in_ready_after"}, int'(bus0.in_ready), 1);
    endtask

    initial begin
        logic [13:0] held;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        drive(1'b0, BLANK, BLANK, BLANK, BLANK);
        set_out_ready(1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", int'(bus0.in_ready), 1);
        check("rst out_valid", int'(bus0.out_valid), 0);
        check("rst valor", int'(bus0.valor), 0);
        check("rst erro_mask", int'(bus0.erro_mask), 0);
        reset = 1'b1;

        send("w1234", SEG[1], SEG[2], SEG[3], SEG[4]);
        check("w1234 valor", int'(bus0.valor), 1234);
        check("w1234 mask", int'(bus0.erro_mask), 0);
        consume("w1234");

        send("w9999", SEG[9], SEG[9], SEG[9], SEG[9]);
        check("w9999 valor", int'(bus0.valor), 9999);
        check("w9999 mask", int'(bus0.erro_mask), 0);
        consume("w9999");

        send("w0000", SEG[0], SEG[0], SEG[0], SEG[0]);
        check("w0000 valor", int'(bus0.valor), 0);
        check("w0000 mask", int'(bus0.erro_mask), 0);
        consume("w0000");

        send("blank", BLANK, BLANK, SEG[4], SEG[2]);
        check("blank1 valor", int'(bus0.valor), 42);
        check("blank1 mask", int'(bus0.erro_mask), 0);
        check("blank0 valor", int'(bus1.valor), 42);
        check("blank0 mask", int'(bus1.erro_mask), 4'b1100);
        consume("blank");

        send("w56x8", SEG[5], SEG[6], 7'b1111110, SEG[8]);
        check("w56x8 valor", int'(bus0.valor), 5608);
        check("w56x8 mask", int'(bus0.erro_mask), 4'b0010);

        // Backpressure: DONE held, input activity ignored.
        held = bus0.valor;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(i[0], SEG[i % 10], SEG[(i + 3) % 10], SEG[(i + 7) % 10], SEG[9 - i]);
            check("bp valor", int'(bus0.valor), 5608);
            check("bp in_ready", int'(bus0.in_ready), 0);
            check("bp out_valid", int'(bus0.out_valid), 1);
        end
        check("bp held", int'(bus0.valor), int'(held));
        drive(1'b0, BLANK, BLANK, BLANK, BLANK);
        consume("bp");
        @(posedge clk);
        #1;
        check("bp no_accept", int'(bus0.in_ready), 1);
        check("bp valor_kept", int'(bus0.valor), 5608);

        // Reset during the second CONV cycle.
        @(negedge clk);
        drive(1'b1, SEG[3], SEG[3], SEG[3], SEG[3]);
        @(posedge clk);
        #1;
        drive(1'b0, BLANK, BLANK, BLANK, BLANK);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort out_valid", int'(bus0.out_valid), 0);
        check("abort valor", int'(bus0.valor), 0);
        check("abort in_ready", int'(bus0.in_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        send("w0007", SEG[0], SEG[0], SEG[0], SEG[7]);
        check("w0007 valor", int'(bus0.valor), 7);
        check("w0007 mask", int'(bus0.erro_mask), 0);
        consume("w0007");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
